// File: rtl/display_pkg.sv
// Shared encodings and snapshot payload for the Connect-4 display path.
package display_pkg;

  localparam int unsigned BOARD_CELLS = 16;

  typedef enum logic [1:0] {
    GS_PLAYING = 2'b00,
    GS_P1_WIN  = 2'b01,
    GS_P2_WIN  = 2'b10,
    GS_DRAW    = 2'b11
  } game_status_e;

  typedef struct packed {
    logic [BOARD_CELLS-1:0] board;
    logic [BOARD_CELLS-1:0] owners;
    game_status_e           status;
  } snapshot_t;

endpackage

// File: rtl/display_tick_gen.sv
// Row-scan timebase: prescaler plus row counter, emitting row and frame ticks.
module display_tick_gen #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [ROW_W-1:0] row_idx,
  output logic             row_tick_c,
  output logic             frame_tick_c
);

  localparam int unsigned PS_W = $clog2(SCAN_DIV);

  logic [PS_W-1:0]  prescaler_q, prescaler_d;
  logic [ROW_W-1:0] row_idx_q, row_idx_d;

  assign row_idx = row_idx_q;

  always_comb begin
    row_tick_c   = (prescaler_q == PS_W'(SCAN_DIV - 1));
    frame_tick_c = row_tick_c && (row_idx_q == ROW_W'(ROWS - 1));
    prescaler_d  = row_tick_c ? '0 : prescaler_q + PS_W'(1);
    row_idx_d    = row_idx_q;
    if (row_tick_c) begin
      row_idx_d = frame_tick_c ? '0 : row_idx_q + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q <= '0;
      row_idx_q   <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      row_idx_q   <= row_idx_d;
    end
  end

endmodule

// File: rtl/board_display_scanner.sv
// Time-multiplexed bi-colour 4x4 LED driver with per-frame snapshot and win/draw blink.
// Blinking is built only when DISPLAY_BLINK_EN is defined; otherwise the display is steady.
module board_display_scanner
  import display_pkg::*;
#(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BOARD_CELLS-1:0] game_board,
  input  logic [BOARD_CELLS-1:0] player_cells,
  input  logic [1:0]             game_status,
  output logic [ROWS-1:0]        row_sel,
  output logic [COLS-1:0]        col_red,
  output logic [COLS-1:0]        col_green,
  output logic                   frame_start
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (ROWS * COLS != BOARD_CELLS || SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_cfg
    $error("board_display_scanner: unsupported ROWS/COLS/SCAN_DIV/BLINK_FRAMES");
  end

  logic [ROW_W-1:0] row_idx;
  logic             row_tick_c, frame_tick_c;

  display_tick_gen #(
    .ROWS     (ROWS),
    .SCAN_DIV (SCAN_DIV),
    .ROW_W    (ROW_W)
  ) u_tick (
    .clk          (clk),
    .reset        (reset),
    .row_idx      (row_idx),
    .row_tick_c   (row_tick_c),
    .frame_tick_c (frame_tick_c)
  );

  snapshot_t       snap_q, snap_d;
  logic            refresh_q, refresh_d;
  logic            frame_pend_q, frame_pend_d;
  logic [ROWS-1:0] row_sel_q, row_sel_d;
  logic [COLS-1:0] col_red_q, col_red_d;
  logic [COLS-1:0] col_green_q, col_green_d;
  logic            frame_start_q, frame_start_d;
  logic [COLS-1:0] board_row_c, owner_row_c, red_c, green_c;
  logic            blink_on_c;

`ifdef DISPLAY_BLINK_EN
  localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_on_q, blink_on_d;

  // Blink phase advances only on frames whose latched status is a result.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_tick_c) begin
      if (game_status_e'(game_status) == GS_PLAYING) begin
        frame_cnt_d = '0;
        blink_on_d  = 1'b1;
      end else if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blink_on_c = blink_on_q;
`else
  assign blink_on_c = 1'b1;
`endif

  always_comb begin
    snap_d = snap_q;
    if (frame_tick_c) begin
      snap_d = '{board: game_board, owners: player_cells, status: game_status_e'(game_status)};
    end
    frame_pend_d = frame_tick_c;
    refresh_d    = row_tick_c;

    board_row_c = snap_q.board[int'(row_idx) * COLS +: COLS];
    owner_row_c = snap_q.owners[int'(row_idx) * COLS +: COLS];
    red_c       = board_row_c & ~owner_row_c;
    green_c     = board_row_c & owner_row_c;
    if (!blink_on_c) begin
      case (snap_q.status)
        GS_P1_WIN: red_c = '0;
        GS_P2_WIN: green_c = '0;
        GS_DRAW: begin
          red_c   = '0;
          green_c = '0;
        end
        default: ;
      endcase
    end

    // Outputs reload one cycle after a row change, so columns always match row_sel.
    row_sel_d     = row_sel_q;
    col_red_d     = col_red_q;
    col_green_d   = col_green_q;
    frame_start_d = frame_pend_q;
    if (refresh_q) begin
      row_sel_d   = ROWS'(1) << row_idx;
      col_red_d   = red_c;
      col_green_d = green_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q        <= '0;
      refresh_q     <= 1'b1;
      frame_pend_q  <= 1'b0;
      row_sel_q     <= '0;
      col_red_q     <= '0;
      col_green_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      snap_q        <= snap_d;
      refresh_q     <= refresh_d;
      frame_pend_q  <= frame_pend_d;
      row_sel_q     <= row_sel_d;
      col_red_q     <= col_red_d;
      col_green_q   <= col_green_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_red     = col_red_q;
  assign col_green   = col_green_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_board_display_scanner.sv
// Self-checking bench for board_display_scanner (SCAN_DIV=4, BLINK_FRAMES=2).
module tb_board_display_scanner;

  localparam int unsigned ROWS         = 4;
  localparam int unsigned COLS         = 4;
  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int unsigned FRAME        = ROWS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] game_board, player_cells;
  logic [1:0]  game_status;
  logic [3:0]  row_sel, col_red, col_green;
  logic        frame_start;

  board_display_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .game_board(game_board), .player_cells(player_cells),
    .game_status(game_status), .row_sel(row_sel), .col_red(col_red),
    .col_green(col_green), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle index since release, frame snapshot, count of result frames.
  int unsigned t;
  logic [15:0] m_board, m_owner;
  logic [1:0]  m_status;
  int unsigned m_k;
  logic [12:0] exp_out;
  bit          chk_en = 0;

  function automatic logic [12:0] model_out(input int unsigned tc, input logic [15:0] b,
                                            input logic [15:0] o, input logic [1:0] s,
                                            input int unsigned k);
    int unsigned row;
    logic [3:0] rs, r, g;
    logic on, fs;
    row = ((tc - 1) / SCAN_DIV) % ROWS;
    rs  = '0;
    rs[row] = 1'b1;
    r = '0;
    g = '0;
    for (int c = 0; c < COLS; c++) begin
      if (b[row * COLS + c]) begin
        if (o[row * COLS + c]) g[c] = 1'b1;
        else r[c] = 1'b1;
      end
    end
`ifdef DISPLAY_BLINK_EN
    on = ((k / BLINK_FRAMES) % 2) == 0;
`else
    on = 1'b1;
`endif
    if (!on) begin
      if (s == 2'b01 || s == 2'b11) r = '0;
      if (s == 2'b10 || s == 2'b11) g = '0;
    end
    fs = (tc > 1) && (((tc - 1) % FRAME) == 0);
    return {rs, r, g, fs};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t = 0; m_board = '0; m_owner = '0; m_status = '0; m_k = 0; exp_out = '0;
    end else begin
      t++;
      exp_out = model_out(t, m_board, m_owner, m_status, m_k);
      if (t % FRAME == 0) begin
        m_board = game_board; m_owner = player_cells; m_status = game_status;
        if (game_status == 2'b00) m_k = 0;
        else m_k++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) check("scan", {19'b0, row_sel, col_red, col_green, frame_start}, {19'b0, exp_out});
  end

  task automatic wait_frame_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 64);
    if (frame_start !== 1'b1) check("frame_start_timeout", {31'b0, frame_start}, 32'd1);
  endtask

  task automatic check_row(input string name, input logic [3:0] rs, input logic [3:0] r,
                           input logic [3:0] g);
    check(name, {20'b0, row_sel, col_red, col_green}, {20'b0, rs, r, g});
  endtask

  typedef struct {
    logic [15:0] board;
    logic [15:0] owners;
    int unsigned row;
    logic [3:0]  exp_red;
    logic [3:0]  exp_green;
  } vec_t;

  vec_t vecs[8];
  logic [3:0] blink_exp[4];

  initial begin
    vecs[0] = '{16'h0021, 16'h0020, 0, 4'b0001, 4'b0000};
    vecs[1] = '{16'h0021, 16'h0020, 1, 4'b0000, 4'b0010};
    vecs[2] = '{16'h0021, 16'h0020, 2, 4'b0000, 4'b0000};
    vecs[3] = '{16'hFFFF, 16'h0F0F, 2, 4'b0000, 4'b1111};
    vecs[4] = '{16'hFFFF, 16'h0F0F, 3, 4'b1111, 4'b0000};
    vecs[5] = '{16'h8421, 16'h8000, 3, 4'b0000, 4'b1000};
    vecs[6] = '{16'h8421, 16'h8000, 2, 4'b0100, 4'b0000};
    vecs[7] = '{16'h0000, 16'hFFFF, 1, 4'b0000, 4'b0000};
`ifdef DISPLAY_BLINK_EN
    blink_exp = '{4'b0001, 4'b0000, 4'b0000, 4'b0001};
`else
    blink_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif

    reset = 1'b1;
    game_board = 16'h0021; player_cells = 16'h0020; game_status = 2'b00;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check_row("reset_outputs", 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    check_row("first_row_blank", 4'b0001, 4'b0000, 4'b0000);

    // Frame period between consecutive frame_start pulses.
    wait_frame_start();
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (frame_start !== 1'b1 && n < 64);
      check("frame_period", 32'(n), 32'(FRAME));
    end

    // Static patterns, one frame each.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] rs;
      @(negedge clk);
      game_board = vecs[i].board; player_cells = vecs[i].owners; game_status = 2'b00;
      wait_frame_start();
      repeat (vecs[i].row * SCAN_DIV) @(negedge clk);
      rs = 4'(1 << vecs[i].row);
      check_row($sformatf("vec%0d", i), rs, vecs[i].exp_red, vecs[i].exp_green);
    end

    // Mid-frame input change stays invisible until the next frame.
    game_board = 16'hFFFF; player_cells = 16'h0000;
    wait_frame_start();
    repeat (2 * SCAN_DIV) @(negedge clk);
    check_row("midframe_row2_pre", 4'b0100, 4'b1111, 4'b0000);
    game_board = 16'h0000;
    repeat (SCAN_DIV) @(negedge clk);
    check_row("midframe_row3_old", 4'b1000, 4'b1111, 4'b0000);
    wait_frame_start();
    check_row("midframe_new_frame", 4'b0001, 4'b0000, 4'b0000);

    // Player 1 win: red blinks, green steady.
    game_board = 16'h0021; player_cells = 16'h0020; game_status = 2'b00;
    wait_frame_start();
    game_status = 2'b01;
    for (int f = 0; f < 4; f++) begin
      wait_frame_start();
      check_row($sformatf("p1win_red_f%0d", f), 4'b0001, blink_exp[f], 4'b0000);
      repeat (SCAN_DIV) @(negedge clk);
      check_row($sformatf("p1win_green_f%0d", f), 4'b0010, 4'b0000, 4'b0010);
    end
    game_status = 2'b11;
    repeat (2) wait_frame_start();
    game_status = 2'b00;
    repeat (2) wait_frame_start();
    check_row("steady_after_play", 4'b0001, 4'b0001, 4'b0000);

    // Player 2 win: green must be steady when blinking is not built.
    game_status = 2'b10;
    repeat (8) wait_frame_start();

    // Asynchronous reset during row 2.
    wait_frame_start();
    repeat (2 * SCAN_DIV) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset", {27'b0, row_sel, frame_start}, 32'd0);
    check("async_reset_cols", {24'b0, col_red, col_green}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_row("restart_row0_blank", 4'b0001, 4'b0000, 4'b0000);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(1, 24)) @(negedge clk);
      game_board   = 16'($urandom);
      player_cells = 16'($urandom);
      if ($urandom_range(0, 3) == 0) game_status = 2'($urandom);
    end
    repeat (2 * FRAME) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
